share_gen_prng: RTL and testbench
=================================

// Module: share_gen_prng
// PURPOSE
//  Upstream masking stage for the 2-share masked AND datapath: splits unmasked
//  bits a,b into Boolean shares (a0,a1),(b0,b1) and supplies one fresh random
//  bit rN per transaction, all drawn from an internal Galois LFSR PRNG.
//  Outputs are registered behind a valid/ready handshake and wire directly to
//  the masked-gate wrapper inputs a0,a1,b0,b1,rN.
// PARAMETERS
//  LFSR_W       32            PRNG state width (>=4)
//  TAPS         32'h80200003  Galois feedback mask (right-shift form)
//  DEFAULT_SEED 32'h1         state substituted when a zero seed is loaded
//  WARMUP       16            PRNG warm-up cycles after each seed load (0 allowed)
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  seed_valid in   1       load seed_data into PRNG this cycle
//  seed_data  in   LFSR_W  seed value
//  in_valid   in   1       unmasked input pair present
//  in_ready   out  1       stage accepts input this cycle
//  a, b       in   1 each  unmasked secret bits
//  out_valid  out  1       share bundle valid
//  out_ready  in   1       consumer takes bundle
//  a0,a1      out  1 each  shares of a
//  b0,b1      out  1 each  shares of b
//  rN         out  1       fresh randomness for the gate
//  seeded     out  1       high in RUN state
// BEHAVIOUR
//  Reset: state=UNSEEDED, lfsr=DEFAULT_SEED, warm counter=0; out_valid,a0,a1,
//   b0,b1,rN,seeded all 0. Reset mid-transfer drops the pending bundle.
//  PRNG step: bit=lfsr[0]; lfsr<=(lfsr>>1)^(bit?TAPS:0). "Draw3" = three
//   chained steps in one cycle giving bits m_a, m_b, r in that order.
//  FSM: UNSEEDED -seed_valid-> WARMUP; WARMUP -count==WARMUP-> RUN;
//   any state -seed_valid-> WARMUP (count restarts at 0). WARMUP=0: RUN the
//   cycle after the seed load.
//  Seed load: lfsr<=(seed_data==0)?DEFAULT_SEED:seed_data; count<=0.
//  WARMUP: one Draw3 per cycle (bits discarded), count+1 per cycle.
//  in_ready = (state==RUN) && !seed_valid && (!out_valid || out_ready),
//   combinational. seed_valid beats a simultaneous in_valid.
//  Transfer (in_valid&&in_ready): one Draw3; next cycle a0=a^m_a, a1=m_a,
//   b0=b^m_b, b1=m_b, rN=r, out_valid=1. Latency 1 cycle. Full throughput
//   with out_ready=1.
//  LFSR advances only on transfer, seed load, or WARMUP; idle RUN holds state.
//  out_valid&&!out_ready: bundle held stable, in_ready=0. out_valid clears
//   on out_ready with no new transfer.
//  Reseed while out_valid: held bundle untouched and still handed over;
//   no new transfer until RUN is regained.
//  Invariant: a0^a1==a and b0^b1==b for every bundle; no unmasked value is
//   ever registered.
// TESTING (LFSR_W=4, TAPS=4'hC, DEFAULT_SEED=4'h1, WARMUP=0 unless stated)
//  1 Reset -> all outputs 0, in_ready=0, seeded=0; in_valid=1 ignored
//   before a seed is loaded.
//  2 seed 4'h1, then a=1,b=1 -> bundle a0=0,a1=1,b0=1,b1=0,rN=0, lfsr=3;
//   next a=0,b=1 -> a0=1,a1=1,b0=0,b1=1,rN=0, lfsr=5.
//  3 seed 4'h0 -> same results as seed 4'h1 (zero-seed substitution).
//  4 out_ready=0 for 3 cycles with out_valid=1 -> bundle stable, in_ready=0,
//   lfsr unchanged; out_ready=1 -> handover, next transfer same cycle.
//  5 WARMUP=4: seed 4'h1 -> in_ready low for exactly 4 cycles after load,
//   seeded rises on the 5th; seed_valid coincident with in_valid in RUN
//   -> no transfer, warm-up restarts.
//  6 1000 random a,b at full throughput, random out_ready -> share
//   invariant holds, no lost/duplicated bundle; rst mid-stream -> out_valid=0
//   next cycle.

Source files
------------

// File: rtl/share_gen_prng.sv
// Boolean-share generator for a 2-share masked AND gate: splits a,b into shares
// and supplies one fresh random bit per bundle, all drawn from an internal Galois LFSR.
module share_gen_prng #(
    parameter int                LFSR_W       = 32,
    parameter logic [LFSR_W-1:0] TAPS         = 32'h80200003,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = {{(LFSR_W-1){1'b0}}, 1'b1},
    parameter int                WARMUP       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              a,
    input  logic              b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              a0,
    output logic              a1,
    output logic              b0,
    output logic              b1,
    output logic              rN,
    output logic              seeded,
    output logic [1:0]        o_dbg_state,
    output logic [LFSR_W-1:0] o_dbg_lfsr
);

    // Handshake: a beat moves on a rising edge where valid && ready are both high.
    // A producer keeps valid and its payload stable until that edge; ready may
    // depend combinationally on the consumer's ready, never on the producer's valid.

    typedef enum logic [1:0] {
        S_UNSEEDED = 2'd0,
        S_WARMUP   = 2'd1,
        S_RUN      = 2'd2
    } state_t;

    localparam int CW = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LFSR_W-1:0] r_lfsr;
    logic [CW-1:0]     r_count;
    logic              r_out_valid;
    logic              r_a0;
    logic              r_a1;
    logic              r_b0;
    logic              r_b1;
    logic              r_rn;

    logic [LFSR_W-1:0] w_s1;
    logic [LFSR_W-1:0] w_s2;
    logic [LFSR_W-1:0] w_s3;
    logic              w_m_a;
    logic              w_m_b;
    logic              w_r;
    logic              w_in_ready;
    logic              w_xfer;
    logic              w_warm_last;

    function automatic logic [LFSR_W-1:0] f_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    // Draw3: three chained steps per cycle; the output bits are the LSBs seen.
    always_comb begin
        w_s1  = f_step(r_lfsr);
        w_s2  = f_step(w_s1);
        w_s3  = f_step(w_s2);
        w_m_a = r_lfsr[0];
        w_m_b = w_s1[0];
        w_r   = w_s2[0];
    end

    assign w_warm_last = (int'(r_count) + 1 == WARMUP);
    assign w_in_ready  = (r_state == S_RUN) && !seed_valid && (!r_out_valid || out_ready);
    assign w_xfer      = in_valid && w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (seed_valid) begin
            w_state_nxt = (WARMUP == 0) ? S_RUN : S_WARMUP;
        end else begin
            case (r_state)
                S_WARMUP: if (w_warm_last) w_state_nxt = S_RUN;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_UNSEEDED;
            r_lfsr  <= DEFAULT_SEED;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (seed_valid) begin
                r_lfsr  <= (seed_data == '0) ? DEFAULT_SEED : seed_data;
                r_count <= '0;
            end else if (r_state == S_WARMUP) begin
                r_lfsr  <= w_s3;
                r_count <= r_count + CW'(1);
            end else if (w_xfer) begin
                r_lfsr <= w_s3;
            end
        end
    end

    // Only masked values are registered: a^m_a is formed before the flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_a0        <= 1'b0;
            r_a1        <= 1'b0;
            r_b0        <= 1'b0;
            r_b1        <= 1'b0;
            r_rn        <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_a0        <= a ^ w_m_a;
            r_a1        <= w_m_a;
            r_b0        <= b ^ w_m_b;
            r_b1        <= w_m_b;
            r_rn        <= w_r;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign a0          = r_a0;
    assign a1          = r_a1;
    assign b0          = r_b0;
    assign b1          = r_b1;
    assign rN          = r_rn;
    assign seeded      = (r_state == S_RUN);
    assign o_dbg_state = r_state;
    assign o_dbg_lfsr  = r_lfsr;

endmodule

// File: tb/tb_share_gen_prng.sv
// Directed bench for share_gen_prng: two instances (no warm-up, 4-cycle warm-up)
// with hand-computed bundles plus a randomised share-invariant scoreboard run.
module tb_share_gen_prng;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       sv0, iv0, ai0, bi0, ordy0;
    logic [3:0] sd0;
    logic       ir0, ov0, a0_0, a1_0, b0_0, b1_0, rn0, sdd0;
    logic [1:0] st0;
    logic [3:0] lf0;

    logic       sv1, iv1, ai1, bi1, ordy1;
    logic [3:0] sd1;
    logic       ir1, ov1, a0_1, a1_1, b0_1, b1_1, rn1, sdd1;
    logic [1:0] st1;
    logic [3:0] lf1;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q[$];
    logic [3:0] m_lfsr;

    share_gen_prng #(.LFSR_W(4), .TAPS(4'hC), .DEFAULT_SEED(4'h1), .WARMUP(0)) u0 (
        .clk(clk), .rst(rst), .seed_valid(sv0), .seed_data(sd0),
        .in_valid(iv0), .in_ready(ir0), .a(ai0), .b(bi0),
        .out_valid(ov0), .out_ready(ordy0),
        .a0(a0_0), .a1(a1_0), .b0(b0_0), .b1(b1_0), .rN(rn0), .seeded(sdd0),
        .o_dbg_state(st0), .o_dbg_lfsr(lf0)
    );

    share_gen_prng #(.LFSR_W(4), .TAPS(4'hC), .DEFAULT_SEED(4'h1), .WARMUP(4)) u1 (
        .clk(clk), .rst(rst), .seed_valid(sv1), .seed_data(sd1),
        .in_valid(iv1), .in_ready(ir1), .a(ai1), .b(bi1),
        .out_valid(ov1), .out_ready(ordy1),
        .a0(a0_1), .a1(a1_1), .b0(b0_1), .b1(b1_1), .rN(rn1), .seeded(sdd1),
        .o_dbg_state(st1), .o_dbg_lfsr(lf1)
    );

    function automatic logic [3:0] step4(input logic [3:0] s);
        return (s >> 1) ^ (s[0] ? 4'hC : 4'h0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bundle order {a0,a1,b0,b1,rN}
    task automatic chk_b0(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, a0_0, a1_0, b0_0, b1_0, rn0}, {27'd0, exp});
    endtask

    task automatic chk_b1(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, a0_1, a1_1, b0_1, b1_1, rn1}, {27'd0, exp});
    endtask

    // Seed, transfer (1,1) then (0,1); optional stall on the first bundle.
    task automatic seed_run(input logic [3:0] s, input int stall);
        sv0 = 1'b1; sd0 = s; iv0 = 1'b0; ordy0 = 1'b1;
        #1;
        chk("seed_cycle_in_ready", {31'd0, ir0}, 32'd0);
        tick();
        sv0 = 1'b0; iv0 = 1'b1; ai0 = 1'b1; bi0 = 1'b1;
        #1;
        chk("run_in_ready", {31'd0, ir0}, 32'd1);
        chk("run_seeded", {31'd0, sdd0}, 32'd1);
        chk("run_state", {30'd0, st0}, 32'd2);
        chk("seed_lfsr", {28'd0, lf0}, 32'h1);
        tick();
        chk("b1_valid", {31'd0, ov0}, 32'd1);
        chk_b0("b1_bundle", 5'b01100);
        chk("b1_lfsr", {28'd0, lf0}, 32'h3);
        ai0 = 1'b0; bi0 = 1'b1;
        for (int i = 0; i < stall; i++) begin
            ordy0 = 1'b0;
            #1;
            chk("stall_in_ready", {31'd0, ir0}, 32'd0);
            tick();
            chk("stall_valid", {31'd0, ov0}, 32'd1);
            chk_b0("stall_bundle", 5'b01100);
            chk("stall_lfsr", {28'd0, lf0}, 32'h3);
        end
        ordy0 = 1'b1;
        #1;
        chk("handover_in_ready", {31'd0, ir0}, 32'd1);
        tick();
        chk("b2_valid", {31'd0, ov0}, 32'd1);
        chk_b0("b2_bundle", 5'b11010);
        chk("b2_lfsr", {28'd0, lf0}, 32'h5);
        iv0 = 1'b0;
        tick();
        chk("drain_valid", {31'd0, ov0}, 32'd0);
        chk("idle_lfsr_hold", {28'd0, lf0}, 32'h5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       exp_ir;
        logic [3:0] s1, s2;

        rst = 1'b1;
        sv0 = 1'b0; sd0 = 4'h0; iv0 = 1'b1; ai0 = 1'b1; bi0 = 1'b1; ordy0 = 1'b1;
        sv1 = 1'b0; sd1 = 4'h0; iv1 = 1'b1; ai1 = 1'b1; bi1 = 1'b0; ordy1 = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_valid", {31'd0, ov0}, 32'd0);
        chk("rst_in_ready", {31'd0, ir0}, 32'd0);
        chk("rst_seeded", {31'd0, sdd0}, 32'd0);
        chk_b0("rst_bundle", 5'b00000);
        chk("rst_lfsr", {28'd0, lf0}, 32'h1);
        chk("rst_state", {30'd0, st0}, 32'd0);
        rst = 1'b0;
        tick();
        chk("unseeded_valid", {31'd0, ov0}, 32'd0);
        chk("unseeded_in_ready", {31'd0, ir0}, 32'd0);
        chk("unseeded_lfsr", {28'd0, lf0}, 32'h1);
        chk("unseeded_state", {30'd0, st0}, 32'd0);
        chk("u1_unseeded_valid", {31'd0, ov1}, 32'd0);

        // Directed bundles, zero-seed substitution, backpressure
        seed_run(4'h1, 0);
        seed_run(4'h0, 0);
        seed_run(4'h1, 3);

        // Warm-up instance: 4 cycles of in_ready low after load
        sv1 = 1'b1; sd1 = 4'h1;
        #1;
        chk("w_load_in_ready", {31'd0, ir1}, 32'd0);
        tick();
        sv1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("w_warm_in_ready", {31'd0, ir1}, 32'd0);
            chk("w_warm_seeded", {31'd0, sdd1}, 32'd0);
            tick();
        end
        chk("w_seeded_rise", {31'd0, sdd1}, 32'd1);
        chk("w_ready_rise", {31'd0, ir1}, 32'd1);
        chk("w_lfsr_after_warm", {28'd0, lf1}, 32'h8);
        sv1 = 1'b1; sd1 = 4'h1;
        #1;
        chk("w_seed_beats_in", {31'd0, ir1}, 32'd0);
        tick();
        chk("w_no_xfer_valid", {31'd0, ov1}, 32'd0);
        chk("w_restart_seeded", {31'd0, sdd1}, 32'd0);
        chk("w_restart_state", {30'd0, st1}, 32'd1);
        chk("w_restart_lfsr", {28'd0, lf1}, 32'h1);
        sv1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("w_rewarm_in_ready", {31'd0, ir1}, 32'd0);
            tick();
        end
        chk("w_reseeded", {31'd0, sdd1}, 32'd1);
        chk("w_relfsr", {28'd0, lf1}, 32'h8);
        tick();
        chk("w_xfer_valid", {31'd0, ov1}, 32'd1);
        chk_b1("w_xfer_bundle", 5'b10000);
        chk("w_xfer_lfsr", {28'd0, lf1}, 32'h1);
        iv1 = 1'b0;

        // Random stream against a scoreboard
        sv0 = 1'b1; sd0 = 4'h9; iv0 = 1'b0; ordy0 = 1'b1;
        tick();
        sv0 = 1'b0;
        m_lfsr = 4'h9;
        for (int n = 0; n < 1000; n++) begin
            chk("rnd_valid", {31'd0, ov0}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk_b0("rnd_bundle", exp_q[0]);
                chk("rnd_inv_a", {31'd0, a0_0 ^ a1_0}, {31'd0, exp_q[0][4] ^ exp_q[0][3]});
            end
            chk("rnd_lfsr", {28'd0, lf0}, {28'd0, m_lfsr});
            ai0 = 1'($urandom_range(0, 1));
            bi0 = 1'($urandom_range(0, 1));
            ordy0 = ($urandom_range(0, 3) != 0);
            iv0 = 1'b1;
            #1;
            exp_ir = (exp_q.size() == 0) || ordy0;
            chk("rnd_in_ready", {31'd0, ir0}, {31'd0, exp_ir});
            if (ordy0 && exp_q.size() != 0) void'(exp_q.pop_front());
            if (exp_ir) begin
                s1 = step4(m_lfsr);
                s2 = step4(s1);
                exp_q.push_back({ai0 ^ m_lfsr[0], m_lfsr[0], bi0 ^ s1[0], s1[0], s2[0]});
                m_lfsr = step4(s2);
            end
            tick();
        end

        // Reset mid-stream drops the pending bundle
        ordy0 = 1'b1; iv0 = 1'b1;
        tick();
        chk("pre_rst_valid", {31'd0, ov0}, 32'd1);
        rst = 1'b1; ordy0 = 1'b0;
        tick();
        chk("mid_rst_valid", {31'd0, ov0}, 32'd0);
        chk("mid_rst_seeded", {31'd0, sdd0}, 32'd0);
        chk("mid_rst_lfsr", {28'd0, lf0}, 32'h1);
        chk("mid_rst_in_ready", {31'd0, ir0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
